sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO: the same-domain counterpart of the two-entry CDC FIFO, generalised to arbitrary width and power-of-two depth. It adds a selectable read mode (standard registered read or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty flags and overflow/underflow error pulses. It buffers data between producer and consumer blocks running on the same clock, and sits on either side of the CDC FIFOs for rate smoothing.

## Interface
- DATA_WIDTH, 8: payload width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- MODE, FIFO_STD: FIFO_STD (registered read) or FIFO_FWFT (head word presented on dout_o).
- AF_THRESH, DEPTH-2: almost_full_o asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 1: almost_empty_o asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- we_i  in  1  write request.
- din_i  in  DATA_WIDTH  write data.
- wrdy_o  out  1  not full; a write is accepted when we_i & wrdy_o.
- re_i  in  1  read request (FWFT: acknowledge/pop).
- dout_o  out  DATA_WIDTH  read data.
- rrdy_o  out  1  not empty; a read is accepted when re_i & rrdy_o.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full_o  out  1  count ≥ AF_THRESH.
- almost_empty_o  out  1  count ≤ AE_THRESH.
- overflow_o  out  1  one-cycle pulse: write attempted while full.
- underflow_o  out  1  one-cycle pulse: read attempted while empty.

## Operation
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The low bits address memory; the MSB is a wrap bit. Pointers increment modulo 2·DEPTH.
- Occupancy: count register equals wr_ptr − rd_ptr. It changes by +1 on write only, −1 on read only, and is unchanged on a simultaneous accepted write and read.
- Flags:
  - wrdy_o = (count != DEPTH).
  - rrdy_o = (count != 0).
  - Almost flags are compared against the count register.
- Write: when we_i & wrdy_o, mem[wr_ptr] ← din_i and wr_ptr increments. A write while full is dropped; memory and pointers are unchanged; overflow_o pulses.
- Full plus simultaneous read: the write is still refused (no pass-through). The read proceeds.
- Empty plus simultaneous write: the read is refused and underflow_o pulses. The write proceeds.
- FIFO_STD read: when re_i & rrdy_o, dout_o ← mem[rd_ptr] on that edge and rd_ptr increments. dout_o holds its value otherwise.
- FIFO_FWFT read: dout_o = mem[rd_ptr] (combinational read) and is valid whenever rrdy_o=1. re_i & rrdy_o pops the entry. dout_o is don't-care while empty.
- Reset (rst_i high, any time, including mid-transfer):
  - Pointers, count and dout_o go to 0; overflow_o and underflow_o go to 0.
  - wrdy_o=1, rrdy_o=0, almost_empty_o=1, almost_full_o=(AF_THRESH==0 ? 1 : 0) (AF_THRESH≥1, so 0).
  - Memory contents are not reset. All requests are ignored while rst_i is high.

## Timing
- Write-to-read latency: a word written at edge N gives rrdy_o=1 after edge N.
  - FWFT: the word is on dout_o after edge N.
  - STD: the word appears on dout_o after the read edge N+1 at the earliest.
- Flags: count_o, wrdy_o, rrdy_o and the almost flags update after the same edge as the causing transfer (no extra lag).
- Error pulses: overflow_o/underflow_o are registered; they are high for exactly the cycle after the offending edge.
- Throughput: one write and one read per cycle, sustained, at any occupancy 1..DEPTH-1.
- Wrap-around: after 2·DEPTH transfers both pointers return to 0 with no bubble.

## Structure
- fifo_pkg: typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}; function for pointer width ($clog2(DEPTH)+1). Shared with future FIFO variants.
- Sub-module fifo_mem: simple dual-port RAM with one synchronous write port and one read port. The read port is asynchronous in FWFT and registered in STD, selected by a parameter.
- Top level holds pointers, count, flag logic and error pulses.

## Test plan
- Fill/drain, DEPTH=16, STD: write 0x00..0x0F back-to-back → wrdy_o=0 and count_o=16 after the 16th edge. Then read 16 → dout_o 0x00..0x0F in order, rrdy_o=0 and count_o=0 at end.
- Overflow/underflow: write 0xAA while full → overflow_o high for one cycle, count stays 16, later drain shows no 0xAA. Read while empty → underflow_o one-cycle pulse, dout_o unchanged.
- Simultaneous, count=5: we_i & re_i for 20 cycles with incrementing data → count_o stays 5, output order intact, pointers wrap. At full, simultaneous we/re → read accepted, write refused, count 15.
- FWFT: write 0x3C to empty FIFO → after that edge rrdy_o=1 and dout_o=0x3C with no re_i. Pulse re_i → rrdy_o=0.
- Thresholds, AF=14, AE=2: count 2→3 deasserts almost_empty_o; count 13→14 asserts almost_full_o, on the same edge as the transfer.
- Reset mid-operation: assert rst_i asynchronously at count=9 between edges → immediately count_o=0, rrdy_o=0, wrdy_o=1, dout_o=0. After release, write 0x11 and read → 0x11 returned.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode selector and pointer sizing.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    // One extra bit above the address width distinguishes full from empty.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, read port either registered or
// asynchronous depending on REG_READ.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The output register is the only reset state; array contents are left alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = REG_READ ? rdata_q : mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, almost-full/empty flags and registered overflow/underflow pulses.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AF_THRESH  = DEPTH - 2,
    parameter int         AE_THRESH  = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [DATA_WIDTH-1:0]       din_i,
    output logic                        wrdy_o,
    input  logic                        re_i,
    output logic [DATA_WIDTH-1:0]       dout_o,
    output logic                        rrdy_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        almost_full_o,
    output logic                        almost_empty_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam int            PW      = fifo_ptr_width(DEPTH);
    localparam int            AW      = PW - 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;
    logic          full, empty, wr_en, rd_en;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Requests are masked during reset so the RAM is not disturbed either.
    assign wr_en = we_i & ~full  & ~rst_i;
    assign rd_en = re_i & ~empty & ~rst_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = we_i & full;
        underflow_d = re_i & empty;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW),
        .REG_READ   (MODE == FIFO_STD)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (din_i),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (dout_o)
    );

    assign wrdy_o         = ~full;
    assign rrdy_o         = ~empty;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a registered-read instance (AF=14, AE=2)
// exercised cycle by cycle, plus a first-word-fall-through instance.
module tb_sync_fifo;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s_we, s_re, s_wrdy, s_rrdy, s_af, s_ae, s_ovf, s_udf;
    logic [7:0] s_din, s_dout;
    logic [4:0] s_count;

    logic       f_we, f_re, f_wrdy, f_rrdy, f_af, f_ae, f_ovf, f_udf;
    logic [7:0] f_din, f_dout;
    logic [4:0] f_count;

    sync_fifo #(
        .DATA_WIDTH (8), .DEPTH (16), .MODE (FIFO_STD), .AF_THRESH (14), .AE_THRESH (2)
    ) u_std (
        .clk_i (clk), .rst_i (rst), .we_i (s_we), .din_i (s_din), .wrdy_o (s_wrdy),
        .re_i (s_re), .dout_o (s_dout), .rrdy_o (s_rrdy), .count_o (s_count),
        .almost_full_o (s_af), .almost_empty_o (s_ae),
        .overflow_o (s_ovf), .underflow_o (s_udf)
    );

    sync_fifo #(
        .DATA_WIDTH (8), .DEPTH (16), .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk_i (clk), .rst_i (rst), .we_i (f_we), .din_i (f_din), .wrdy_o (f_wrdy),
        .re_i (f_re), .dout_o (f_dout), .rrdy_o (f_rrdy), .count_o (f_count),
        .almost_full_o (f_af), .almost_empty_o (f_ae),
        .overflow_o (f_ovf), .underflow_o (f_udf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         m_count;
    logic [7:0] m_dout;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the registered-read instance, checked against the model.
    task automatic step(input logic we, input logic [7:0] d, input logic re);
        logic w_ok, r_ok;
        w_ok = we && (m_count != 16);
        r_ok = re && (m_count != 0);
        s_we = we; s_din = d; s_re = re;
        @(posedge clk); #1;
        s_we = 1'b0; s_re = 1'b0;
        if (r_ok) m_dout = sb.pop_front();
        if (w_ok) sb.push_back(d);
        m_count = m_count + int'(w_ok) - int'(r_ok);
        $display("txn we=%0b din=%02h re=%0b -> count=%0d dout=%02h ovf=%0b udf=%0b",
                 we, d, re, s_count, s_dout, s_ovf, s_udf);
        check("dout",   s_dout, m_dout);
        check("count",  s_count, m_count);
        check("ovf",    s_ovf, we && !w_ok);
        check("udf",    s_udf, re && !r_ok);
        check("wrdy",   s_wrdy, m_count != 16);
        check("rrdy",   s_rrdy, m_count != 0);
        check("afull",  s_af, m_count >= 14);
        check("aempty", s_ae, m_count <= 2);
    endtask

    initial begin
        rst = 1'b1;
        s_we = 1'b0; s_re = 1'b0; s_din = '0;
        f_we = 1'b0; f_re = 1'b0; f_din = '0;
        m_count = 0; m_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", s_count, 0);
        check("rst_wrdy",  s_wrdy, 1);
        check("rst_rrdy",  s_rrdy, 0);
        check("rst_ae",    s_ae, 1);
        check("rst_af",    s_af, 0);
        check("rst_dout",  s_dout, 0);
        check("rst_ovf",   s_ovf, 0);
        check("rst_udf",   s_udf, 0);
        check("rst_fcount", f_count, 0);
        check("rst_frrdy", f_rrdy, 0);
        #2 rst = 1'b0;

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Steady-state simultaneous traffic at count 5, wrapping both pointers.
        for (int i = 0; i < 5; i++)  step(1'b1, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h50 + 8'(i), 1'b1);

        // Full plus read: write refused. Empty plus write: read refused.
        for (int i = 0; i < 11; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h99, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // First-word-fall-through behaviour.
        f_we = 1'b1; f_din = 8'h3C;
        @(posedge clk); #1;
        f_we = 1'b0;
        check("fwft_rrdy",  f_rrdy, 1);
        check("fwft_dout",  f_dout, 8'h3C);
        check("fwft_count", f_count, 1);
        @(posedge clk); #1;
        check("fwft_hold",  f_dout, 8'h3C);
        f_re = 1'b1;
        @(posedge clk); #1;
        f_re = 1'b0;
        check("fwft_pop_rrdy",  f_rrdy, 0);
        check("fwft_pop_count", f_count, 0);
        f_we = 1'b1; f_din = 8'hA1;
        @(posedge clk); #1;
        f_din = 8'hB2;
        @(posedge clk); #1;
        f_we = 1'b0;
        check("fwft_head1", f_dout, 8'hA1);
        check("fwft_cnt2",  f_count, 2);
        f_re = 1'b1;
        @(posedge clk); #1;
        check("fwft_head2", f_dout, 8'hB2);
        @(posedge clk); #1;
        f_re = 1'b0;
        check("fwft_empty", f_rrdy, 0);

        // Asynchronous reset between edges, with the FIFO part full.
        for (int i = 0; i < 9; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_count", s_count, 0);
        check("arst_rrdy",  s_rrdy, 0);
        check("arst_wrdy",  s_wrdy, 1);
        check("arst_dout",  s_dout, 0);
        check("arst_ae",    s_ae, 1);
        s_we = 1'b1; s_din = 8'hFF;
        @(posedge clk); #1;
        s_we = 1'b0;
        check("arst_ignore", s_count, 0);
        #2 rst = 1'b0;
        m_count = 0; m_dout = '0; sb.delete();
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
